rr_arbiter_mux4: RTL and testbench

- Round-robin arbiter for four requesters that share the 4-input, 4-bit multiplexer channel.
- Grants one requester at a time and drives the mux select, so the winner's 4-bit data appears on the shared channel.
- Holds each grant until the downstream consumer acknowledges, the requester withdraws, or a timeout expires.
- Sits between the four data sources and the shared mux/consumer.

---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 48 ++++
 rtl/rr_arbiter_mux4.sv | 132 +++++++++++++
 tb/tb_rr_arbiter_mux4.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   - state_e : arbiter FSM states
//   - N_REQ   : number of requesters
//   - SEL_W   : width of the mux select / priority pointer
//   - PTR_RST : pointer value after reset (source 0 searched first)
//   - onehot4 : index -> one-hot grant vector
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
// Searches req_i starting one position after ptr_i and wrapping around,
// so the source at ptr_i itself is examined last.
//   req_i   [3:0] request vector
//   ptr_i   [1:0] index of the most recently served source
//   found_o       at least one request is set
//   idx_o   [1:0] index of the winning source (0 when none)
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand1_d;
  logic [SEL_W-1:0] cand2_d;
  logic [SEL_W-1:0] cand3_d;

  // 2-bit addition wraps naturally, giving the modulo-4 search order
  assign cand1_d = ptr_i + 2'd1;
  assign cand2_d = ptr_i + 2'd2;
  assign cand3_d = ptr_i + 2'd3;

  // first set request in rotated priority order wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    if (req_i[cand1_d]) begin
      found_o = 1'b1;
      idx_o   = cand1_d;
    end else if (req_i[cand2_d]) begin
      found_o = 1'b1;
      idx_o   = cand2_d;
    end else if (req_i[cand3_d]) begin
      found_o = 1'b1;
      idx_o   = cand3_d;
    end else if (req_i[ptr_i]) begin
      found_o = 1'b1;
      idx_o   = ptr_i;
    end else begin
      found_o = 1'b0;
      idx_o   = 2'd0;
    end
  end

endmodule

// File: rtl/rr_arbiter_mux4.sv
// Round-robin arbiter in front of a shared 4:1, 4-bit mux channel.
// Grants one source at a time, drives the mux select and holds the grant
// until ack, withdrawal of the request, or an age timeout.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_i[3:0] per-source request
//   ack_i      consumer accepted channel data (only meaningful while valid)
//   sel_o[1:0] mux select, index of granted source (holds while idle)
//   gnt_o[3:0] one-hot grant
//   valid_o    grant active / channel data valid
//   done_o     one-cycle pulse, transfer acknowledged
//   timeout_o  one-cycle pulse, grant released by timeout
module rr_arbiter_mux4
  import rr_arb_pkg::*;
#(
  parameter int P_TIMEOUT = 15,
  parameter int P_CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             ack_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam logic [P_CNT_W-1:0] LP_AGE_LAST = P_CNT_W'(P_TIMEOUT - 1);
  localparam logic [P_CNT_W-1:0] LP_AGE_ONE  = P_CNT_W'(1);

  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [P_CNT_W-1:0] age_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               valid_q;
  logic               done_q;
  logic               timeout_q;

  logic [SEL_W-1:0]   arb_ptr_d;
  logic               win_found_d;
  logic [SEL_W-1:0]   win_idx_d;
  logic               rel_ack_d;
  logic               rel_wd_d;
  logic               rel_to_d;
  logic               release_d;

  // Every release in GRANT moves ptr to sel before re-arbitrating, so the
  // picker can be fed sel directly in that state and a single instance
  // covers both the idle search and back-to-back re-grants.
  assign arb_ptr_d = (state_q == ST_GRANT) ? sel_q : ptr_q;

  rr_pick4 u_pick (
    .req_i   (req_i),
    .ptr_i   (arb_ptr_d),
    .found_o (win_found_d),
    .idx_o   (win_idx_d)
  );

  assign rel_ack_d = ack_i;
  assign rel_wd_d  = ~req_i[sel_q];
  assign rel_to_d  = (age_q == LP_AGE_LAST);
  assign release_d = rel_ack_d | rel_wd_d | rel_to_d;

  // arbiter FSM with registered channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      age_q     <= '0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found_d) begin
            state_q <= ST_GRANT;
            sel_q   <= win_idx_d;
            gnt_q   <= onehot4(win_idx_d);
            valid_q <= 1'b1;
            age_q   <= '0;
          end else begin
            // sel keeps its last value so the mux output stays stable
            valid_q <= 1'b0;
            gnt_q   <= 4'b0000;
          end
        end
        ST_GRANT: begin
          if (release_d) begin
            ptr_q     <= sel_q;
            // ack outranks both withdrawal and timeout
            done_q    <= rel_ack_d;
            timeout_q <= ~rel_ack_d & ~rel_wd_d & rel_to_d;
            if (win_found_d) begin
              sel_q   <= win_idx_d;
              gnt_q   <= onehot4(win_idx_d);
              valid_q <= 1'b1;
              age_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= 4'b0000;
              valid_q <= 1'b0;
              age_q   <= '0;
            end
          end else begin
            age_q <= age_q + LP_AGE_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
          age_q   <= '0;
        end
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign gnt_o     = gnt_q;
  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_mux4.sv
module tb_rr_arbiter_mux4;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid, done, timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       done;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  // reference model state: granted source (-1 = none), its age, last served
  int m_gnt = -1;
  int m_age = 0;
  int m_ptr = 3;
  int m_sel = 0;
  bit m_done = 1'b0;
  bit m_to = 1'b0;

  rr_arbiter_mux4 #(.P_TIMEOUT(TMO), .P_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .ack_i     (ack),
    .sel_o     (sel),
    .gnt_o     (gnt),
    .valid_o   (valid),
    .done_o    (done),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.sel   = 2'(m_sel);
    e.gnt   = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
    e.valid = (m_gnt >= 0);
    e.done  = m_done;
    e.to    = m_to;
    return e;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_age = 0; m_ptr = 3; m_sel = 0; m_done = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a, input logic rn);
    int w;
    if (!rn) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    m_to = 1'b0;
    if (m_gnt < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_gnt = w; m_sel = w; m_age = 0;
      end
    end else if (a || !r[m_gnt] || m_age == TMO - 1) begin
      if (a) m_done = 1'b1;
      else if (r[m_gnt]) m_to = 1'b1;
      m_ptr = m_gnt;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_gnt = w; m_sel = w; m_age = 0;
      end else begin
        m_gnt = -1;
      end
    end else begin
      m_age = m_age + 1;
    end
  endtask

  // advance one cycle: model consumes the inputs the DUT just sampled
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(req, ack, rst_n);
    exp_q.push_back(cur_exp());
  endtask

  task automatic drv(input logic [3:0] r, input logic a);
    tick();
    req = r;
    ack = a;
  endtask

  task automatic check_reset_now(input string name);
    checks++;
    if (sel !== 2'd0 || gnt !== 4'b0000 || valid !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s got sel=%0d gnt=%b valid=%b done=%b to=%b want all zero",
               name, sel, gnt, valid, done, timeout);
    end
  endtask

  // asynchronous reset between edges; outputs must clear immediately
  task automatic async_reset();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_now("async_reset");
    void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(cur_exp());
  endtask

  // monitor: compare DUT outputs to the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (sel !== e.sel || gnt !== e.gnt || valid !== e.valid || done !== e.done || timeout !== e.to) begin
        errors++;
        $display("FAIL out t=%0t got sel=%0d gnt=%b valid=%b done=%b to=%b want sel=%0d gnt=%b valid=%b done=%b to=%b",
                 $time, sel, gnt, valid, done, timeout, e.sel, e.gnt, e.valid, e.done, e.to);
      end
      checks++;
      if (((gnt & (gnt - 4'd1)) != 4'b0000) || (valid != (gnt != 4'b0000)) ||
          (valid && !gnt[sel]) || (done && timeout)) begin
        errors++;
        $display("FAIL invariant t=%0t got sel=%0d gnt=%b valid=%b done=%b to=%b",
                 $time, sel, gnt, valid, done, timeout);
      end
    end
  end

  initial begin
    bit hit;
    #1;
    check_reset_now("reset_state");
    model_reset();
    drv(4'b0000, 1'b0);
    drv(4'b0000, 1'b0);
    tick();
    rst_n = 1'b1;

    // single requester, ack, then idle with sel held
    drv(4'b0001, 1'b0);
    drv(4'b0001, 1'b0);
    drv(4'b0001, 1'b1);
    drv(4'b0000, 1'b0);
    repeat (3) drv(4'b0000, 1'b0);

    // all requesting with ack every cycle: rotation
    repeat (12) drv(4'b1111, 1'b1);
    drv(4'b0000, 1'b0);
    drv(4'b0000, 1'b0);

    // sole requester without ack: timeout and immediate re-grant
    repeat (36) drv(4'b0100, 1'b0);
    drv(4'b0000, 1'b0);
    drv(4'b0000, 1'b0);

    // withdrawal of source 1 while source 3 waits
    drv(4'b0010, 1'b0);
    drv(4'b0010, 1'b0);
    drv(4'b1000, 1'b0);
    drv(4'b1000, 1'b1);
    drv(4'b0000, 1'b0);
    drv(4'b0000, 1'b0);

    // ack plus withdrawal on the edge where age reaches 14
    drv(4'b0001, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (m_gnt == 0 && m_age == TMO - 2) begin
        req = 4'b0000; ack = 1'b1; hit = 1'b1;
      end else begin
        req = 4'b0001; ack = 1'b0;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL age14_setup got hit=0 want hit=1");
    end
    drv(4'b0000, 1'b0);
    drv(4'b0000, 1'b0);

    // reset mid-grant, then full request starts at source 0
    drv(4'b0100, 1'b0);
    drv(4'b0100, 1'b0);
    drv(4'b0100, 1'b0);
    async_reset();
    drv(4'b1111, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (4) drv(4'b1111, 1'b1);
    drv(4'b0000, 1'b0);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        async_reset();
        tick();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        drv(4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
      end else begin
        drv(req, 1'($urandom_range(0, 5) == 0));
      end
    end
    drv(4'b0000, 1'b0);
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
